// File: rtl/cios_result_collector.sv
// Word-serial output stage of the CIOS Montgomery array: buffers T and T-N while
// loading, picks the reduced result once the top word and final borrow are known.
module cios_result_collector #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_t,
  input  logic [WIDTH-1:0] in_n,
  input  logic [WIDTH-1:0] in_top,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_last,
  output logic             sub_done,
  output logic             proto_err
);

  localparam int              IW       = $clog2(NWORDS);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NWORDS - 1);
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]   IDX_ZERO = IW'(0);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_DECIDE = 2'd1,
    ST_EMIT   = 2'd2
  } state_e;

  // {borrow_out, difference} of a - b - bin, borrow_out lands in bit WIDTH
  function automatic logic [WIDTH:0] sub_word(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             bin);
    sub_word = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
  endfunction

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              borrow_q, borrow_d;
  logic              top_nz_q, top_nz_d;
  logic              fborrow_q, fborrow_d;
  logic              sel_q, sel_d;
  logic              proto_err_q, proto_err_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_word_q, out_word_d;
  logic              out_last_q, out_last_d;
  logic              sub_done_q, sub_done_d;

  logic [WIDTH-1:0]  tbuf_q [NWORDS];
  logic [WIDTH-1:0]  dbuf_q [NWORDS];

  logic              in_hs_s;
  logic              out_hs_s;
  logic              idx_last_s;
  logic [IW-1:0]     idx_nx_s;
  logic [WIDTH:0]    diff_s;
  logic [IW-1:0]     rd_idx_s;
  logic              rd_sel_s;
  logic              load_rd_s;

  assign in_hs_s    = in_valid & in_ready_q & (state_q == ST_LOAD);
  assign out_hs_s   = out_valid_q & out_ready;
  assign idx_last_s = (idx_q == LAST_IDX);
  assign idx_nx_s   = idx_q + IDX_ONE;
  assign diff_s     = sub_word(in_t, in_n, borrow_q);

  // Next-state and output-register logic for the LOAD/DECIDE/EMIT sequence
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    borrow_d    = borrow_q;
    top_nz_d    = top_nz_q;
    fborrow_d   = fborrow_q;
    sel_d       = sel_q;
    proto_err_d = proto_err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_last_d  = out_last_q;
    sub_done_d  = sub_done_q;
    rd_idx_s    = idx_q;
    rd_sel_s    = sel_q;
    load_rd_s   = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (in_hs_s) begin
          borrow_d = diff_s[WIDTH];
          if (in_last != idx_last_s) begin
            proto_err_d = 1'b1;
          end else begin
            proto_err_d = proto_err_q;
          end
          // The beat count, not in_last, ends the load phase
          if (idx_last_s) begin
            top_nz_d   = |in_top;
            fborrow_d  = diff_s[WIDTH];
            idx_d      = IDX_ZERO;
            in_ready_d = 1'b0;
            state_d    = ST_DECIDE;
          end else begin
            idx_d = idx_nx_s;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_DECIDE: begin
        sel_d       = top_nz_q | ~fborrow_q;
        rd_sel_s    = sel_d;
        rd_idx_s    = IDX_ZERO;
        load_rd_s   = 1'b1;
        out_valid_d = 1'b1;
        out_last_d  = (LAST_IDX == IDX_ZERO);
        sub_done_d  = sel_d;
        state_d     = ST_EMIT;
      end

      ST_EMIT: begin
        if (out_hs_s) begin
          if (idx_last_s) begin
            idx_d       = IDX_ZERO;
            borrow_d    = 1'b0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_word_d  = {WIDTH{1'b0}};
            out_last_d  = 1'b0;
            sub_done_d  = 1'b0;
            state_d     = ST_LOAD;
          end else begin
            idx_d      = idx_nx_s;
            rd_idx_s   = idx_nx_s;
            load_rd_s  = 1'b1;
            out_last_d = (idx_nx_s == LAST_IDX);
          end
        end else begin
          state_d = ST_EMIT;
        end
      end

      default: begin
        state_d     = ST_LOAD;
        idx_d       = IDX_ZERO;
        borrow_d    = 1'b0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out_word_d  = {WIDTH{1'b0}};
        out_last_d  = 1'b0;
        sub_done_d  = 1'b0;
      end
    endcase

    if (load_rd_s) begin
      out_word_d = rd_sel_s ? dbuf_q[rd_idx_s] : tbuf_q[rd_idx_s];
    end else begin
      out_word_d = out_word_d;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      idx_q       <= IDX_ZERO;
      borrow_q    <= 1'b0;
      top_nz_q    <= 1'b0;
      fborrow_q   <= 1'b0;
      sel_q       <= 1'b0;
      proto_err_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_word_q  <= {WIDTH{1'b0}};
      out_last_q  <= 1'b0;
      sub_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      borrow_q    <= borrow_d;
      top_nz_q    <= top_nz_d;
      fborrow_q   <= fborrow_d;
      sel_q       <= sel_d;
      proto_err_q <= proto_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_last_q  <= out_last_d;
      sub_done_q  <= sub_done_d;
    end
  end

  // Raw and subtracted word buffers; contents only matter after a full load
  always_ff @(posedge clk) begin
    if (in_hs_s && !rst) begin
      tbuf_q[idx_q] <= in_t;
      dbuf_q[idx_q] <= diff_s[WIDTH-1:0];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_last  = out_last_q;
  assign sub_done  = sub_done_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cios_result_collector.sv
// Scoreboard bench: directed NWORDS=2 vectors plus an NWORDS=8 randomised run
// against a wide-integer reference of the conditional subtraction.
module tb_cios_result_collector;

  typedef struct packed {
    logic [15:0] w;
    logic        l;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid2, in_ready2, in_last2, out_valid2, out_ready2, out_last2, sub_done2, proto_err2;
  logic [15:0] in_t2, in_n2, in_top2, out_word2;
  logic        in_valid8, in_ready8, in_last8, out_valid8, out_ready8, out_last8, sub_done8, proto_err8;
  logic [15:0] in_t8, in_n8, in_top8, out_word8;

  exp_t q2[$];
  exp_t q8[$];
  bit   lat_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n_out8 = 0;
  bit rnd_ready8 = 1'b0;

  always #5 clk = ~clk;

  cios_result_collector #(.WIDTH(16), .NWORDS(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_t(in_t2), .in_n(in_n2),
    .in_top(in_top2), .in_last(in_last2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_word(out_word2),
    .out_last(out_last2), .sub_done(sub_done2), .proto_err(proto_err2)
  );

  cios_result_collector #(.WIDTH(16), .NWORDS(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_t(in_t8), .in_n(in_n8),
    .in_top(in_top8), .in_last(in_last8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_word(out_word8),
    .out_last(out_last8), .sub_done(sub_done8), .proto_err(proto_err8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the NWORDS=2 instance
  logic        stall2_q = 1'b0, rst2_q = 1'b0;
  logic [15:0] hw2_q;
  logic        hl2_q, hs2_q;
  always @(negedge clk) begin
    exp_t e;
    if (stall2_q && !rst2_q) begin
      chk("hold_valid2", out_valid2, 1);
      chk("hold_word2", out_word2, hw2_q);
      chk("hold_last2", out_last2, hl2_q);
      chk("hold_sub2", sub_done2, hs2_q);
    end
    if (out_valid2 === 1'b1) chk("no_in_during_out2", in_ready2, 0);
    if (out_valid2 === 1'b1 && out_ready2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk("unexpected_word2", out_valid2, 0);
      end else begin
        e = q2.pop_front();
        chk("word2", out_word2, e.w);
        chk("last2", out_last2, e.l);
        chk("sub2", sub_done2, e.s);
      end
    end
    stall2_q <= (out_valid2 === 1'b1) && (out_ready2 === 1'b0);
    rst2_q   <= rst;
    hw2_q    <= out_word2;
    hl2_q    <= out_last2;
    hs2_q    <= sub_done2;
  end

  // Monitor for the NWORDS=8 instance, including load-to-output latency
  logic        stall8_q = 1'b0, ov8_q = 1'b0;
  logic [15:0] hw8_q;
  logic        hl8_q, hs8_q;
  int          bc8 = 0;
  int          last_hs8 = 0;
  always @(negedge clk) begin
    exp_t e;
    bit lf;
    if (stall8_q) begin
      chk("hold_valid8", out_valid8, 1);
      chk("hold_word8", out_word8, hw8_q);
      chk("hold_last8", out_last8, hl8_q);
      chk("hold_sub8", sub_done8, hs8_q);
    end
    if (out_valid8 === 1'b1 && ov8_q === 1'b0) begin
      if (lat_q.size() != 0) begin
        lf = lat_q.pop_front();
        if (lf) chk("latency8", cyc - last_hs8, 2);
      end
    end
    if (rst) begin
      bc8 <= 0;
    end else if (in_valid8 === 1'b1 && in_ready8 === 1'b1) begin
      if (bc8 == 7) begin
        bc8      <= 0;
        last_hs8 <= cyc;
      end else begin
        bc8 <= bc8 + 1;
      end
    end
    if (out_valid8 === 1'b1 && out_ready8 === 1'b1) begin
      n_out8 <= n_out8 + 1;
      if (q8.size() == 0) begin
        chk("unexpected_word8", out_valid8, 0);
      end else begin
        e = q8.pop_front();
        chk("word8", out_word8, e.w);
        chk("last8", out_last8, e.l);
        chk("sub8", sub_done8, e.s);
      end
    end
    stall8_q <= (out_valid8 === 1'b1) && (out_ready8 === 1'b0);
    ov8_q    <= (out_valid8 === 1'b1);
    hw8_q    <= out_word8;
    hl8_q    <= out_last8;
    hs8_q    <= sub_done8;
  end

  // Downstream ready for the wide instance: random 70% duty once enabled
  initial begin
    out_ready8 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready8 = rnd_ready8 ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
  end

  task automatic wait_hs2();
    int to = 0;
    @(negedge clk);
    while (in_ready2 !== 1'b1 && to < 100) begin
      @(negedge clk);
      to++;
    end
    if (to >= 100) chk("in_hs_timeout2", in_ready2, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs8();
    int to = 0;
    @(negedge clk);
    while (in_ready8 !== 1'b1 && to < 500) begin
      @(negedge clk);
      to++;
    end
    if (to >= 500) chk("in_hs_timeout8", in_ready8, 1);
    @(posedge clk);
    #1;
  endtask

  // N = {0x0003, 0x0001}; in_top carries junk except on the counted last beat
  task automatic drive2(input logic [15:0] t0, input logic [15:0] t1, input logic [15:0] top,
                        input logic l0, input logic l1);
    for (int i = 0; i < 2; i++) begin
      in_valid2 = 1'b1;
      in_t2     = (i == 0) ? t0 : t1;
      in_n2     = (i == 0) ? 16'h0003 : 16'h0001;
      in_last2  = (i == 0) ? l0 : l1;
      in_top2   = (i == 1) ? top : 16'hBEEF;
      wait_hs2();
    end
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
    in_t2     = 16'h5A5A;
    in_top2   = 16'h7777;
  endtask

  task automatic push2(input logic [15:0] w0, input logic [15:0] w1, input logic s);
    exp_t e;
    e.w = w0; e.l = 1'b0; e.s = s; q2.push_back(e);
    e.w = w1; e.l = 1'b1; e.s = s; q2.push_back(e);
  endtask

  task automatic wait_empty2();
    int to = 0;
    while (q2.size() != 0 && to < 200) begin
      @(posedge clk);
      #1;
      to++;
    end
    if (to >= 200) chk("drain_timeout2", q2.size(), 0);
  endtask

  task automatic drive8(input logic [127:0] t, input logic [15:0] top, input logic [127:0] n,
                        input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        int k;
        k = $urandom_range(0, 2);
        in_valid8 = 1'b0;
        in_t8     = 16'($urandom);
        repeat (k) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid8 = 1'b1;
      in_t8     = t[16*i +: 16];
      in_n8     = n[16*i +: 16];
      in_last8  = (i == 7);
      in_top8   = (i == 7) ? top : 16'($urandom);
      wait_hs8();
    end
    in_valid8 = 1'b0;
    in_last8  = 1'b0;
    in_top8   = 16'hFFFF;
  endtask

  logic [127:0] n128;
  logic [159:0] nw, two_n, r, t, res;
  bit           sb;
  exp_t         e8;
  int           to;

  initial begin
    rst = 1'b1;
    in_valid2 = 1'b0; in_t2 = 16'h0; in_n2 = 16'h0; in_top2 = 16'h0; in_last2 = 1'b0; out_ready2 = 1'b1;
    in_valid8 = 1'b0; in_t8 = 16'h0; in_n8 = 16'h0; in_top8 = 16'h0; in_last8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready2, 1);
    chk("rst_out_valid", out_valid2, 0);
    chk("rst_out_word", out_word2, 0);
    chk("rst_out_last", out_last2, 0);
    chk("rst_sub_done", sub_done2, 0);
    chk("rst_proto_err", proto_err2, 0);
    chk("rst_out_valid8", out_valid8, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", in_ready2, 1);

    // 1: T < N, output stalled for a few cycles
    out_ready2 = 1'b0;
    push2(16'h0005, 16'h0000, 1'b0);
    drive2(16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    out_ready2 = 1'b1;
    wait_empty2();
    // 2: T > N
    push2(16'h0002, 16'h0000, 1'b1);
    drive2(16'h0005, 16'h0001, 16'h0000, 1'b0, 1'b1);
    wait_empty2();
    // 3: T == N
    push2(16'h0000, 16'h0000, 1'b1);
    drive2(16'h0003, 16'h0001, 16'h0000, 1'b0, 1'b1);
    wait_empty2();
    // 4: nonzero top word forces subtraction
    push2(16'hFFFE, 16'hFFFE, 1'b1);
    drive2(16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b1);
    wait_empty2();
    chk("proto_err_clean", proto_err2, 0);

    // 6a: early in_last
    push2(16'h0005, 16'h0000, 1'b0);
    drive2(16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b1);
    wait_empty2();
    chk("proto_err_set", proto_err2, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("proto_err_sticky", proto_err2, 1);

    // 6b: reset after the first output word
    begin
      exp_t e;
      e.w = 16'h0002; e.l = 1'b0; e.s = 1'b1;
      q2.push_back(e);
    end
    drive2(16'h0005, 16'h0001, 16'h0000, 1'b0, 1'b1);
    to = 0;
    @(negedge clk);
    while (out_valid2 !== 1'b1 && to < 20) begin
      @(negedge clk);
      to++;
    end
    if (to >= 20) chk("out_valid_timeout2", out_valid2, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready2 = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_out_valid", out_valid2, 0);
    chk("abort_out_word", out_word2, 0);
    chk("abort_out_last", out_last2, 0);
    chk("abort_sub_done", sub_done2, 0);
    chk("abort_proto_err", proto_err2, 0);
    chk("abort_first_word_seen", q2.size(), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_in_ready", in_ready2, 1);
    out_ready2 = 1'b1;

    // 6c: fresh operation after the abort
    push2(16'h0002, 16'h0000, 1'b1);
    drive2(16'h0005, 16'h0001, 16'h0000, 1'b0, 1'b1);
    wait_empty2();

    // 5: NWORDS=8 random T < 2N against wide-integer reference
    rnd_ready8 = 1'b1;
    for (int k = 0; k < 200; k++) begin
      n128 = {$urandom, $urandom, $urandom, $urandom};
      if (n128 == 128'd0) n128 = 128'd1;
      nw    = {32'd0, n128};
      two_n = nw << 1;
      r     = {$urandom, $urandom, $urandom, $urandom, $urandom};
      case (k)
        0:       t = nw;
        1:       t = nw - 160'd1;
        2:       t = two_n - 160'd1;
        3:       t = 160'd0;
        default: t = r % two_n;
      endcase
      if (t >= nw) begin
        res = t - nw;
        sb  = 1'b1;
      end else begin
        res = t;
        sb  = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        e8.w = res[16*i +: 16];
        e8.l = (i == 7);
        e8.s = sb;
        q8.push_back(e8);
      end
      lat_q.push_back(k < 50);
      drive8(t[127:0], t[143:128], n128, k >= 50);
    end
    to = 0;
    while (q8.size() != 0 && to < 5000) begin
      @(posedge clk);
      #1;
      to++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("q8_drained", q8.size(), 0);
    chk("words_out8", n_out8, 1600);
    chk("lat_q_drained", lat_q.size(), 0);
    chk("proto_err8_clean", proto_err8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cios_result_collector.md
# cios_result_collector

Word-serial output stage for the CIOS Montgomery multiplier array. It collects the final S-word stream and the top carry word, least-significant word first, together with the matching modulus words. It performs the conditional final subtraction (T ≥ N → T − N) on the fly during loading. It then streams the reduced result out over a valid/ready handshake.

## Interface
- WIDTH, 16, word width; matches the PE word width.
- NWORDS, 8, words per operand; must be ≥ 2.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  collector accepts a beat.
- in_t  in  WIDTH  result word T[i] from the array, LSW first.
- in_n  in  WIDTH  modulus word N[i], same index as in_t.
- in_top  in  WIDTH  final carry word T[NWORDS]; sampled only on the beat with in_last.
- in_last  in  1  marks the beat with index NWORDS−1.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_word  out  WIDTH  reduced result word, LSW first.
- out_last  out  1  marks output word NWORDS−1.
- sub_done  out  1  level; 1 when the emitted result is T − N. Valid while out_valid=1.
- proto_err  out  1  sticky error; in_last disagreed with the beat count. Cleared only by rst.

## Operation
- Storage: two NWORDS×WIDTH buffers, TBUF (raw T) and DBUF (T − N).
- Index counter: log2(NWORDS) bits wide, plus a 1-bit borrow register.
- FSM states are LOAD, DECIDE and EMIT.
- LOAD:
  - in_ready=1.
  - On each handshake at index i: TBUF[i]←in_t; {borrow', DBUF[i]} ← in_t − in_n − borrow, computed at WIDTH+1 bits; borrow←borrow'; idx←idx+1.
  - Borrow is 0 at index 0.
  - On the beat with idx=NWORDS−1: capture top_nz = (in_top≠0) and the final borrow', clear idx, go to DECIDE.
  - The transition is driven by the count, not by in_last.
- proto_err: set if in_last=1 at idx≠NWORDS−1, or in_last=0 at idx=NWORDS−1. Processing continues as if in_last were correct.
- DECIDE (one cycle): sel_d ← top_nz | ~final_borrow, then go to EMIT. in_ready=0.
- EMIT:
  - out_valid=1; out_word = sel_d ? DBUF[idx] : TBUF[idx].
  - out_last = (idx=NWORDS−1); sub_done=sel_d.
  - On handshake: idx+1. On the handshake with out_last: idx←0, borrow←0, go to LOAD.
  - out_word, out_last and sub_done hold stable while out_valid=1 and out_ready=0.
- Arithmetic: subtraction is modulo 2^WIDTH per word. The top word never enters the subtraction. A nonzero top forces T − N, and the borrow out of T − N is discarded.
- No input is accepted during DECIDE or EMIT; no output is presented during LOAD.

## Timing
- Reset values: state=LOAD, idx=0, borrow=0, sel_d=0, proto_err=0, out_valid=0, out_word=0, out_last=0, sub_done=0.
- in_ready=1 in the first cycle after rst deasserts.
- rst asserted in any state aborts the operation next edge. Partial buffer contents are discarded and all outputs return to their reset values.
- Throughput: one input beat per cycle in LOAD; one output word per cycle in EMIT when out_ready=1.
- Latency: from the last input handshake (cycle c), DECIDE occupies c+1 and out_valid=1 from c+2.
- Minimum operation length: NWORDS + 1 + NWORDS cycles.
- in_ready rises in the cycle after the out_last handshake. There is no overlap between operations.
- in_valid gaps in LOAD stall the counter with no state change. out_ready gaps in EMIT hold the outputs.
- in_top and in_t/in_n are ignored on cycles without an input handshake.

## Test plan
Scenarios 1–4 and 6 use WIDTH=16, NWORDS=2 and N words {0x0003, 0x0001} (N=0x00010003).
1. T words {0x0005, 0x0000}, top=0 → out {0x0005, 0x0000}, sub_done=0, out_last on the second word, proto_err=0.
2. T words {0x0005, 0x0001}, top=0 → out {0x0002, 0x0000}, sub_done=1.
3. T=N exactly, top=0 → out {0x0000, 0x0000}, sub_done=1 (equality subtracts).
4. T words {0x0001, 0x0000}, top=0x0001 → out {0xFFFE, 0xFFFE}, sub_done=1.
5. NWORDS=8, random in_valid and out_ready duty cycles, 200 random T<2N against a golden model:
   - outputs match, with no word dropped or duplicated;
   - outputs hold while stalled;
   - first out_valid occurs exactly 2 cycles after the last input handshake when in_valid is continuous.
6. Misuse and reset:
   - in_last=1 on beat 0 → proto_err=1 and stays 1, and the operation still completes with 2 output words.
   - rst asserted after the first output word → next cycle out_valid=0, in_ready=1 after deassert, proto_err=0.
   - A fresh scenario-2 operation afterwards yields {0x0002, 0x0000}.
